// File: rtl/iq_upconv_pkg.sv
// Shared types and helpers for the fs/4 quadrature upconverter.
// Holds the FSM state enum, phase type, sideband codes and a saturating negate.
package iq_upconv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    typedef logic [1:0] phase_t;

    localparam logic SB_UPPER = 1'b0;
    localparam logic SB_LOWER = 1'b1;

    localparam int unsigned SAT_MAX_W = 64;

    // x is a w-bit value sign-extended to SAT_MAX_W; the most negative value maps to the most positive
    function automatic logic [SAT_MAX_W-1:0] sat_neg(input logic [SAT_MAX_W-1:0] x,
                                                      input int unsigned w);
        logic [SAT_MAX_W-1:0] one;
        logic [SAT_MAX_W-1:0] hi;
        logic [SAT_MAX_W-1:0] lo;
        one = SAT_MAX_W'(1);
        hi  = (one << (w - 1)) - one;
        lo  = ~hi;
        return (x == lo) ? hi : (~x + one);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// One-entry AXI-stream holding buffer with synchronous flush.
// A pop and a push in the same cycle keep the entry full with the new data.
module axis_skid_buffer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              aclk,
    input  logic              arst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready
);

    logic              full;
    logic [DATA_W-1:0] data;
    logic              push;
    logic              pop;

    assign s_tready = !full || m_tready;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tready && full;
    assign m_tdata  = data;
    assign m_tvalid = full;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else begin
            if (pop) begin
                full <= 1'b0;
            end
            if (push) begin
                full <= 1'b1;
                data <= s_tdata;
            end
        end
    end

endmodule

// File: rtl/axis_iq_upconverter.sv
// fs/4 quadrature upconverter: I/Q at 1/OSR rate in, one real mixed sample per clock out.
// Define IQ_UPCONV_STATS_EN to add the saturating underflow_count port.
module axis_iq_upconverter
    import iq_upconv_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OSR   = 4
) (
    input  logic               aclk,
    input  logic               arst_n,
    input  logic               enable,
    input  logic               sideband,
    input  logic [2*WIDTH-1:0] s_axis_data_tdata,
    input  logic               s_axis_data_tvalid,
    output logic               s_axis_data_tready,
    output logic [WIDTH-1:0]   m_axis_data_tdata,
    output logic               m_axis_data_tvalid,
    output logic               underflow
`ifdef IQ_UPCONV_STATS_EN
    ,
    output logic [15:0]        underflow_count
`endif
);

    localparam int unsigned CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
    localparam int unsigned EXT_W = SAT_MAX_W - WIDTH;

    state_t               state;
    state_t               state_next;
    phase_t               phase;
    logic [CNT_W-1:0]     sample_cnt;
    logic [WIDTH-1:0]     cur_i;
    logic [WIDTH-1:0]     cur_q;
    logic                 sb_hold;
    logic                 sb_eff;
    logic                 boundary;
    logic                 uf_event;
    logic                 buf_ready;
    logic                 buf_full;
    logic                 buf_flush;
    logic [2*WIDTH-1:0]   buf_data;
    logic [SAT_MAX_W-1:0] neg_i_ext;
    logic [SAT_MAX_W-1:0] neg_q_ext;
    logic [WIDTH-1:0]     neg_i;
    logic [WIDTH-1:0]     neg_q;
    logic [WIDTH-1:0]     mix;

    assign boundary  = (state == RUN) && (sample_cnt == CNT_LAST);
    assign uf_event  = boundary && !buf_full;
    assign buf_flush = (state != RUN) || !enable;

    axis_skid_buffer #(
        .DATA_W (2 * WIDTH)
    ) u_buf (
        .aclk     (aclk),
        .arst_n   (arst_n),
        .flush    (buf_flush),
        .s_tdata  (s_axis_data_tdata),
        .s_tvalid (s_axis_data_tvalid && (state == RUN)),
        .s_tready (buf_ready),
        .m_tdata  (buf_data),
        .m_tvalid (buf_full),
        .m_tready (boundary)
    );

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        s_axis_data_tready = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = PRIME;
            end
            PRIME: begin
                s_axis_data_tready = 1'b1;
                if (!enable)                 state_next = IDLE;
                else if (s_axis_data_tvalid) state_next = RUN;
            end
            RUN: begin
                s_axis_data_tready = buf_ready;
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign neg_i_ext = sat_neg({{EXT_W{cur_i[WIDTH-1]}}, cur_i}, WIDTH);
    assign neg_q_ext = sat_neg({{EXT_W{cur_q[WIDTH-1]}}, cur_q}, WIDTH);
    assign neg_i     = neg_i_ext[WIDTH-1:0];
    assign neg_q     = neg_q_ext[WIDTH-1:0];

    // sideband is live on phase 0 and frozen for the rest of the 4-phase group
    assign sb_eff = (phase == 2'd0) ? sideband : sb_hold;

    always_comb begin
        mix = cur_i;
        case (phase)
            2'd0: mix = cur_i;
            2'd1: mix = (sb_eff == SB_LOWER) ? cur_q : neg_q;
            2'd2: mix = neg_i;
            2'd3: mix = (sb_eff == SB_LOWER) ? neg_q : cur_q;
            default: mix = cur_i;
        endcase
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            phase              <= '0;
            sample_cnt         <= '0;
            cur_i              <= '0;
            cur_q              <= '0;
            sb_hold            <= SB_UPPER;
            m_axis_data_tdata  <= '0;
            m_axis_data_tvalid <= 1'b0;
            underflow          <= 1'b0;
        end else if (enable && (state == PRIME)) begin
            m_axis_data_tdata  <= '0;
            m_axis_data_tvalid <= 1'b0;
            underflow          <= 1'b0;
            if (s_axis_data_tvalid) begin
                cur_i      <= s_axis_data_tdata[WIDTH-1:0];
                cur_q      <= s_axis_data_tdata[2*WIDTH-1:WIDTH];
                phase      <= '0;
                sample_cnt <= '0;
            end
        end else if (enable && (state == RUN)) begin
            m_axis_data_tdata  <= mix;
            m_axis_data_tvalid <= 1'b1;
            underflow          <= uf_event;
            phase              <= phase + 2'd1;
            sb_hold            <= sb_eff;
            sample_cnt         <= boundary ? '0 : sample_cnt + CNT_W'(1);
            if (boundary) begin
                cur_i <= buf_full ? buf_data[WIDTH-1:0] : '0;
                cur_q <= buf_full ? buf_data[2*WIDTH-1:WIDTH] : '0;
            end
        end else begin
            phase              <= '0;
            sample_cnt         <= '0;
            cur_i              <= '0;
            cur_q              <= '0;
            sb_hold            <= SB_UPPER;
            m_axis_data_tdata  <= '0;
            m_axis_data_tvalid <= 1'b0;
            underflow          <= 1'b0;
        end
    end

`ifdef IQ_UPCONV_STATS_EN
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            underflow_count <= '0;
        end else if ((state == IDLE) && enable) begin
            underflow_count <= '0;
        end else if (enable && uf_event && (underflow_count != '1)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`else
    // Without stats only the underflow pulse is reported.
`endif

endmodule

// File: tb/tb_axis_iq_upconverter.sv
// Self-checking bench: random AXI-stream source against a sample-stream model of the upconverter.
module tb_axis_iq_upconverter;

    localparam int W     = 16;
    localparam int OSR_T = 4;

    logic             aclk = 1'b0;
    logic             arst_n;
    logic             enable;
    logic             sideband;
    logic [2*W-1:0]   s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic [W-1:0]     m_tdata;
    logic             m_tvalid;
    logic             underflow;
`ifdef IQ_UPCONV_STATS_EN
    logic [15:0]      underflow_count;
`endif

    always #5 aclk = ~aclk;

    axis_iq_upconverter #(
        .WIDTH (W),
        .OSR   (OSR_T)
    ) dut (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .enable             (enable),
        .sideband           (sideband),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .underflow          (underflow)
`ifdef IQ_UPCONV_STATS_EN
        ,
        .underflow_count    (underflow_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (sample-stream view) ----------------
    int m_state = 0;            // 0 idle, 1 waiting for first sample, 2 running
    int k       = 0;            // output index since the first sample was taken
    int cur_i   = 0;
    int cur_q   = 0;
    int bq_i[$];
    int bq_q[$];
    bit sb_grp  = 0;
    int e_data  = 0;
    bit e_valid = 0;
    bit e_uf    = 0;
    int e_cnt   = 0;
    bit mdl_tr, mdl_hs;
    int mdl_ph, mdl_di, mdl_dq;

    function automatic int neg(input int x);
        int mn;
        mn = -(1 <<< (W - 1));
        return (x == mn) ? -mn - 1 : -x;
    endfunction

    function automatic int mixv(input int i, input int q, input int ph, input bit lsb);
        case (ph)
            0: return i;
            1: return lsb ? q : neg(q);
            2: return neg(i);
            default: return lsb ? neg(q) : q;
        endcase
    endfunction

    function automatic bit model_tready();
        if (m_state == 1) return 1'b1;
        if (m_state == 2) return (bq_i.size() == 0) || ((k % OSR_T) == OSR_T - 1);
        return 1'b0;
    endfunction

    always @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            m_state = 0; k = 0; cur_i = 0; cur_q = 0; sb_grp = 0;
            bq_i.delete(); bq_q.delete();
            e_data = 0; e_valid = 0; e_uf = 0; e_cnt = 0;
        end else begin
            mdl_tr = model_tready();
            mdl_hs = s_tvalid && mdl_tr;
            mdl_di = $signed(s_tdata[W-1:0]);
            mdl_dq = $signed(s_tdata[2*W-1:W]);
            e_uf   = 0;
            if (!enable) begin
                m_state = 0; bq_i.delete(); bq_q.delete();
                e_data = 0; e_valid = 0;
            end else if (m_state == 0) begin
                m_state = 1; e_cnt = 0; e_data = 0; e_valid = 0;
            end else if (m_state == 1) begin
                e_data = 0; e_valid = 0;
                if (mdl_hs) begin
                    cur_i = mdl_di; cur_q = mdl_dq; m_state = 2; k = 0;
                end
            end else begin
                mdl_ph = k % 4;
                if (mdl_ph == 0) sb_grp = sideband;
                e_data  = mixv(cur_i, cur_q, mdl_ph, sb_grp);
                e_valid = 1;
                if ((k % OSR_T) == OSR_T - 1) begin
                    if (bq_i.size() > 0) begin
                        cur_i = bq_i.pop_front(); cur_q = bq_q.pop_front();
                    end else begin
                        cur_i = 0; cur_q = 0; e_uf = 1;
                        if (e_cnt < 65535) e_cnt++;
                    end
                end
                if (mdl_hs) begin
                    bq_i.push_back(mdl_di); bq_q.push_back(mdl_dq);
                end
                k++;
            end
        end
    end

    // ---------------- compare and observation ----------------
    int cyc = 0;
    int obs[$];
    int obs_cyc[$];
    int uf_pulses = 0;
    int uf_idx    = -1;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        check("m_tdata", $signed(m_tdata), e_data);
        check("m_tvalid", m_tvalid, e_valid);
        check("s_tready", s_tready, model_tready());
        check("underflow", underflow, e_uf);
`ifdef IQ_UPCONV_STATS_EN
        check("underflow_count", underflow_count, e_cnt);
`endif
    end

    always @(negedge aclk) begin
        if (m_tvalid) begin
            obs.push_back(int'($signed(m_tdata)));
            obs_cyc.push_back(cyc);
        end
        if (underflow) begin
            uf_pulses++;
            uf_idx = obs.size();
        end
    end

    function automatic int obs_at(input int idx);
        return (idx >= 0 && idx < obs.size()) ? obs[idx] : 999999;
    endfunction

    function automatic int obs_cyc_at(input int idx);
        return (idx >= 0 && idx < obs_cyc.size()) ? obs_cyc[idx] : -999;
    endfunction

    // ---------------- stimulus ----------------
    int          src_i     = 0;
    int          src_q     = 0;
    bit          rand_data = 0;
    bit          rand_sb   = 0;
    int unsigned valid_pct = 100;
    bit          will_hs   = 0;
    int          prime_cyc = -1;

    task automatic tick();
        @(posedge aclk);
        #2;
        if (will_hs && rand_data) begin
            src_i = $urandom_range(65535) - 32768;
            src_q = $urandom_range(65535) - 32768;
        end
        if (rand_sb) sideband = $urandom_range(1);
        s_tvalid = ($urandom_range(99) < valid_pct);
        s_tdata  = {src_q[W-1:0], src_i[W-1:0]};
        will_hs  = s_tvalid && s_tready;
        if (will_hs && prime_cyc < 0) prime_cyc = cyc + 1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic restart();
        enable = 0;
        run_cycles(2);
        obs.delete();
        obs_cyc.delete();
        prime_cyc = -1;
        enable = 1;
    endtask

    initial begin
        int n;
        arst_n = 0; enable = 0; sideband = 0; s_tvalid = 0; s_tdata = '0;
        run_cycles(2);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tdata", $signed(m_tdata), 0);
        check("rst_underflow", underflow, 0);
        arst_n = 1;
        run_cycles(2);

        // constant I=1000, Q=0, upper sideband
        src_i = 1000; src_q = 0;
        restart();
        run_cycles(20);
        check("t1_p0", obs_at(0), 1000);
        check("t1_p1", obs_at(1), 0);
        check("t1_p2", obs_at(2), -1000);
        check("t1_p3", obs_at(3), 0);
        check("t1_p4", obs_at(4), 1000);
        check("t1_latency", obs_cyc_at(0), prime_cyc + 1);

        // enable dropped mid-RUN, then restart from phase 0
        enable = 0;
        tick();
        check("en_drop_tvalid", m_tvalid, 0);
        check("en_drop_tready", s_tready, 0);
        check("en_drop_tdata", $signed(m_tdata), 0);
        restart();
        run_cycles(12);
        check("en_restart_p0", obs_at(0), 1000);
        check("en_restart_p2", obs_at(2), -1000);
        check("en_restart_latency", obs_cyc_at(0), prime_cyc + 1);

        // I=0, Q=500, sideband switched to lower in the middle of a group
        src_i = 0; src_q = 500; sideband = 0;
        restart();
        n = 0;
        while (obs.size() < 6 && n < 50) begin tick(); n++; end
        check("t2_wait", n < 50, 1);
        sideband = 1;
        run_cycles(16);
        check("t2_usb_p1", obs_at(1), -500);
        check("t2_usb_p3", obs_at(3), 500);
        check("t2_held_p3", obs_at(7), 500);
        check("t2_lsb_p0", obs_at(8), 0);
        check("t2_lsb_p1", obs_at(9), 500);
        check("t2_lsb_p3", obs_at(11), -500);

        // full-scale negative inputs saturate on negation
        src_i = -32768; src_q = -32768; sideband = 0;
        restart();
        run_cycles(12);
        check("t3_p0", obs_at(0), -32768);
        check("t3_p1", obs_at(1), 32767);
        check("t3_p2", obs_at(2), 32767);
        check("t3_p3", obs_at(3), -32768);

        // source stalls long enough to miss exactly one sample boundary
        rand_data = 1; valid_pct = 100;
        restart();
        run_cycles(20);
        n = 0;
        while (s_tready && n < 20) begin tick(); n++; end
        check("t4_full_wait", n < 20, 1);
        uf_pulses = 0;
        valid_pct = 0;
        n = 0;
        while (uf_pulses == 0 && n < 40) begin tick(); n++; end
        check("t4_uf_wait", n < 40, 1);
        valid_pct = 100;
        run_cycles(20);
        check("t4_uf_pulses", uf_pulses, 1);
        for (int j = 0; j < OSR_T; j++) check("t4_zero_out", obs_at(uf_idx + j), 0);
`ifdef IQ_UPCONV_STATS_EN
        check("t4_uf_count", underflow_count, 1);
`endif

        // continuous source with random data and sideband: no underflow
        rand_sb = 1;
        uf_pulses = 0;
        run_cycles(1000);
        check("t5_no_underflow", uf_pulses, 0);

        // bursty source, underflows handled by the model
        valid_pct = 60;
        run_cycles(400);

        // asynchronous reset mid-RUN, then re-prime
        rand_sb = 0; sideband = 0; rand_data = 0; valid_pct = 100;
        src_i = 1234; src_q = -77;
        @(posedge aclk);
        #2;
        arst_n = 0;
        #1;
        check("arst_tvalid", m_tvalid, 0);
        check("arst_tready", s_tready, 0);
        check("arst_tdata", $signed(m_tdata), 0);
        check("arst_underflow", underflow, 0);
        run_cycles(2);
        obs.delete();
        obs_cyc.delete();
        prime_cyc = -1;
        arst_n = 1;
        run_cycles(12);
        check("arst_restart_p0", obs_at(0), 1234);
        check("arst_restart_p1", obs_at(1), 77);
        check("arst_restart_latency", obs_cyc_at(0), prime_cyc + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
